// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble packer slice: nibble width, accumulator
// FSM state encoding and the count-width helper.
package nibble_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [0:0] {
        ACC_FILL = 1'b0,
        ACC_HELD = 1'b1
    } acc_state_e;

    // Width needed to hold a count in 0..n.
    function automatic int unsigned nib_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nibble_acc.sv
// Nibble accumulator: writes accepted nibbles into successive slots, tracks
// the fill index and flag count, and detects word completion.
// The "next_*" outputs are the word including the nibble being accepted this
// cycle, so the top level can load it straight into the output register.
// The "held_*" outputs are the registered (frozen) word used from ACC_HELD.
// Optional feature macro: NIBBLE_PACKER_PARITY_EN (running XOR of the word).
module nibble_acc
    import nibble_pkg::*;
#(
    parameter int unsigned NUM_NIB = 4,
    parameter int unsigned CNT_W   = nib_cnt_w(NUM_NIB)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     accept,
    input  logic                     clear,
    input  logic [NIB_W-1:0]         nib,
    input  logic                     flag,
    input  logic                     last,
    output logic                     complete,
    output logic [NIB_W*NUM_NIB-1:0] next_data,
    output logic [CNT_W-1:0]         next_cnt,
    output logic [CNT_W-1:0]         next_flags,
    output logic [NIB_W*NUM_NIB-1:0] held_data,
    output logic [CNT_W-1:0]         held_cnt,
    output logic [CNT_W-1:0]         held_flags
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic                     next_parity,
    output logic                     held_parity
`endif
);

    logic [NIB_W*NUM_NIB-1:0] data_q, data_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         flags_q, flags_d;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic                     parity_q, parity_d;
`endif

    // Word as it would look with the current nibble written, plus completion.
    always_comb begin
        next_data = data_q;
        for (int unsigned k = 0; k < NUM_NIB; k++) begin
            if (idx_q == CNT_W'(k)) begin
                next_data[k*NIB_W +: NIB_W] = nib;
            end
        end
        next_cnt   = idx_q + CNT_W'(1);
        next_flags = flags_q + CNT_W'(flag);
`ifdef NIBBLE_PACKER_PARITY_EN
        next_parity = parity_q ^ (^nib);
`endif
        complete = accept && ((idx_q == CNT_W'(NUM_NIB - 1)) || last);
    end

    // Next-state: clear has priority so a word handed off this cycle does not
    // linger in the accumulator.
    always_comb begin
        data_d  = data_q;
        idx_d   = idx_q;
        flags_d = flags_q;
`ifdef NIBBLE_PACKER_PARITY_EN
        parity_d = parity_q;
`endif
        if (clear) begin
            data_d  = '0;
            idx_d   = '0;
            flags_d = '0;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_d = 1'b0;
`endif
        end else if (accept) begin
            data_d  = next_data;
            idx_d   = next_cnt;
            flags_d = next_flags;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_d = next_parity;
`endif
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            idx_q   <= '0;
            flags_q <= '0;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // A completed word freezes with idx one past its last slot, so idx is
    // also the valid-slot count while held.
    always_comb begin
        held_data  = data_q;
        held_cnt   = idx_q;
        held_flags = flags_q;
`ifdef NIBBLE_PACKER_PARITY_EN
        held_parity = parity_q;
`endif
    end

endmodule

// File: rtl/nibble_packer.sv
// Nibble packer top: packs NUM_NIB nibbles (or fewer, on in_last) into one
// word. Holds the accumulator FSM, the output register and both handshakes;
// the accumulator and output register form a two-deep buffer.
// Optional feature macro: NIBBLE_PACKER_PARITY_EN adds the out_parity port.
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int unsigned NUM_NIB = 4,
    parameter int unsigned CNT_W   = nib_cnt_w(NUM_NIB)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W-1:0]         in_nib,
    input  logic                     in_flag,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NUM_NIB-1:0] out_data,
    output logic [CNT_W-1:0]         out_cnt,
    output logic [CNT_W-1:0]         out_flags
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    acc_state_e               state_q, state_d;
    logic                     out_valid_q, out_valid_d;
    logic [NIB_W*NUM_NIB-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]         out_flags_q, out_flags_d;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic                     out_parity_q, out_parity_d;
    logic                     next_parity, held_parity;
`endif

    logic                     accept;
    logic                     drain;
    logic                     out_free;
    logic                     acc_clear;
    logic                     complete;
    logic [NIB_W*NUM_NIB-1:0] next_data, held_data;
    logic [CNT_W-1:0]         next_cnt, held_cnt;
    logic [CNT_W-1:0]         next_flags, held_flags;

    nibble_acc #(
        .NUM_NIB (NUM_NIB),
        .CNT_W   (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (accept),
        .clear       (acc_clear),
        .nib         (in_nib),
        .flag        (in_flag),
        .last        (in_last),
        .complete    (complete),
        .next_data   (next_data),
        .next_cnt    (next_cnt),
        .next_flags  (next_flags),
        .held_data   (held_data),
        .held_cnt    (held_cnt),
        .held_flags  (held_flags)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,
        .next_parity (next_parity),
        .held_parity (held_parity)
`endif
    );

    // Handshake qualifiers; in_ready depends on state alone.
    always_comb begin
        in_ready = (state_q == ACC_FILL);
        accept   = in_valid && in_ready;
        drain    = out_valid_q && out_ready;
        out_free = !out_valid_q || out_ready;
    end

    // FSM and output-register next state. A drain and a load in the same
    // edge keep out_valid high, so there is no bubble between words.
    always_comb begin
        state_d     = state_q;
        acc_clear   = 1'b0;
        out_valid_d = out_valid_q && !drain;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_flags_d = out_flags_q;
`ifdef NIBBLE_PACKER_PARITY_EN
        out_parity_d = out_parity_q;
`endif
        case (state_q)
            ACC_FILL: begin
                if (complete) begin
                    if (out_free) begin
                        out_valid_d = 1'b1;
                        out_data_d  = next_data;
                        out_cnt_d   = next_cnt;
                        out_flags_d = next_flags;
`ifdef NIBBLE_PACKER_PARITY_EN
                        out_parity_d = next_parity;
`endif
                        acc_clear   = 1'b1;
                    end else begin
                        state_d = ACC_HELD;
                    end
                end
            end
            ACC_HELD: begin
                if (drain) begin
                    out_valid_d = 1'b1;
                    out_data_d  = held_data;
                    out_cnt_d   = held_cnt;
                    out_flags_d = held_flags;
`ifdef NIBBLE_PACKER_PARITY_EN
                    out_parity_d = held_parity;
`endif
                    acc_clear   = 1'b1;
                    state_d     = ACC_FILL;
                end
            end
            default: begin
                state_d = ACC_FILL;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC_FILL;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_flags_q <= '0;
`ifdef NIBBLE_PACKER_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_flags_q <= out_flags_d;
`ifdef NIBBLE_PACKER_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    // Registered outputs.
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_cnt   = out_cnt_q;
        out_flags = out_flags_q;
`ifdef NIBBLE_PACKER_PARITY_EN
        out_parity = out_parity_q;
`endif
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed testbench for nibble_packer (NUM_NIB=4). Inputs change and
// outputs are sampled on the falling clock edge.
// Optional feature macro: NIBBLE_PACKER_PARITY_EN enables the parity checks.
module tb_nibble_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_nib;
    logic        in_flag;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_cnt;
    logic [2:0]  out_flags;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic        out_parity;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    nibble_packer #(
        .NUM_NIB (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_nib    (in_nib),
        .in_flag   (in_flag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_flags (out_flags)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one nibble for one cycle.
    task automatic send(input logic [3:0] nib, input logic flag, input logic last);
        in_valid = 1'b1;
        in_nib   = nib;
        in_flag  = flag;
        in_last  = last;
        @(negedge clk);
    endtask

    // One cycle with nothing offered.
    task automatic idle();
        in_valid = 1'b0;
        in_nib   = 4'h0;
        in_flag  = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_nib    = 4'h0;
        in_flag   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_cnt !== 3'd0 || out_flags !== 3'd0) begin
            errors++; $display("FAIL reset_cnt_flags: got cnt=%0d flags=%0d expected 0/0", out_cnt, out_flags);
        end
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        send(4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 1'b0);
        send(4'h3, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b expected 0", out_valid); end
        send(4'h4, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_data !== 16'h4321) begin errors++; $display("FAIL full_data: got %h expected 4321", out_data); end
        checks++;
        if (out_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt: got %0d expected 4", out_cnt); end
        checks++;
        if (out_flags !== 3'd0) begin errors++; $display("FAIL full_flags: got %0d expected 0", out_flags); end
`ifdef NIBBLE_PACKER_PARITY_EN
        checks++;
        if (out_parity !== 1'b1) begin errors++; $display("FAIL parity_4321: got %b expected 1", out_parity); end
`endif
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_one_cycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_early_last();
        out_ready = 1'b1;
        send(4'h5, 1'b0, 1'b0);
        send(4'h6, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0065) begin
            errors++; $display("FAIL last_data: got valid=%b data=%h expected 1/0065", out_valid, out_data);
        end
        checks++;
        if (out_cnt !== 3'd2) begin errors++; $display("FAIL last_cnt: got %0d expected 2", out_cnt); end
        send(4'h7, 1'b0, 1'b1);
        checks++;
        if (out_data !== 16'h0007 || out_cnt !== 3'd1) begin
            errors++; $display("FAIL last_slot0: got data=%h cnt=%0d expected 0007/1", out_data, out_cnt);
        end
        // in_last on the final slot closes exactly one full word.
        send(4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 1'b0);
        send(4'h3, 1'b0, 1'b0);
        send(4'h4, 1'b0, 1'b1);
        checks++;
        if (out_data !== 16'h4321 || out_cnt !== 3'd4) begin
            errors++; $display("FAIL last_on_full: got data=%h cnt=%0d expected 4321/4", out_data, out_cnt);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL last_on_full_single: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send(4'(i), 1'b0, 1'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
            errors++; $display("FAIL bp_first_word: got valid=%b data=%h expected 1/4321", out_valid, out_data);
        end
        idle();
        checks++;
        if (out_data !== 16'h4321 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stable: got data=%h in_ready=%b expected 4321/0", out_data, in_ready);
        end
        out_ready = 1'b1;
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8765) begin
            errors++; $display("FAIL bp_second_word: got valid=%b data=%h expected 1/8765", out_valid, out_data);
        end
        checks++;
        if (out_cnt !== 3'd4) begin errors++; $display("FAIL bp_second_cnt: got %0d expected 4", out_cnt); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        send(4'hF, 1'b1, 1'b0);
        send(4'h0, 1'b0, 1'b0);
        send(4'hF, 1'b1, 1'b0);
        send(4'hF, 1'b1, 1'b0);
        checks++;
        if (out_data !== 16'hFF0F) begin errors++; $display("FAIL flags_data: got %h expected ff0f", out_data); end
        checks++;
        if (out_flags !== 3'd3) begin errors++; $display("FAIL flags_count: got %0d expected 3", out_flags); end
`ifdef NIBBLE_PACKER_PARITY_EN
        checks++;
        if (out_parity !== 1'b0) begin errors++; $display("FAIL parity_ff0f: got %b expected 0", out_parity); end
`endif
        idle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(4'h1, 1'b0, 1'b1);
        checks++;
        if (out_data !== 16'h0001 || out_cnt !== 3'd1) begin
            errors++; $display("FAIL b2b_first: got data=%h cnt=%0d expected 0001/1", out_data, out_cnt);
        end
        send(4'hF, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h000F || out_flags !== 3'd1) begin
            errors++; $display("FAIL b2b_second: got valid=%b data=%h flags=%0d expected 1/000f/1",
                               out_valid, out_data, out_flags);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(4'h9, 1'b0, 1'b0);
        send(4'h9, 1'b0, 1'b0);
        send(4'h9, 1'b0, 1'b0);
        send(4'h9, 1'b1, 1'b0);
        send(4'h1, 1'b0, 1'b0);
        send(4'h2, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h9999) begin
            errors++; $display("FAIL arst_pre: got valid=%b data=%h expected 1/9999", out_valid, out_data);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            errors++; $display("FAIL arst_out: got valid=%b data=%h expected 0/0000", out_valid, out_data);
        end
        checks++;
        if (out_cnt !== 3'd0 || out_flags !== 3'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL arst_misc: got cnt=%0d flags=%0d in_ready=%b expected 0/0/1",
                               out_cnt, out_flags, in_ready);
        end
`ifdef NIBBLE_PACKER_PARITY_EN
        checks++;
        if (out_parity !== 1'b0) begin errors++; $display("FAIL arst_parity: got %b expected 0", out_parity); end
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(4'hA, 1'b0, 1'b0);
        send(4'hB, 1'b0, 1'b0);
        send(4'hC, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_partial_dropped: got %b expected 0", out_valid); end
        send(4'hD, 1'b0, 1'b0);
        checks++;
        if (out_data !== 16'hDCBA || out_cnt !== 3'd4 || out_flags !== 3'd0) begin
            errors++; $display("FAIL arst_after: got data=%h cnt=%0d flags=%0d expected dcba/4/0",
                               out_data, out_cnt, out_flags);
        end
        idle();
    endtask

    task automatic test_parity();
`ifdef NIBBLE_PACKER_PARITY_EN
        out_ready = 1'b1;
        send(4'h3, 1'b0, 1'b0);
        send(4'h3, 1'b0, 1'b0);
        send(4'h0, 1'b0, 1'b0);
        send(4'h0, 1'b0, 1'b0);
        checks++;
        if (out_data !== 16'h0033 || out_parity !== 1'b0) begin
            errors++; $display("FAIL parity_0033: got data=%h parity=%b expected 0033/0", out_data, out_parity);
        end
        send(4'h7, 1'b0, 1'b1);
        checks++;
        if (out_data !== 16'h0007 || out_parity !== 1'b1) begin
            errors++; $display("FAIL parity_0007: got data=%h parity=%b expected 0007/1", out_data, out_parity);
        end
        idle();
`endif
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_early_last();
        test_backpressure();
        test_flags();
        test_back_to_back();
        test_async_reset();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream stage of the 4-bit nibble formatter. Consumes the per-cycle nibble and its all-ones flag (the `&`-reduction of the nibble) and packs `NUM_NIB` consecutive nibbles into one word. Supports early word closure on `in_last`. The accumulator and output register are double-buffered, so packing continues while a finished word waits on backpressure. Valid/ready handshakes on both sides.

## Interface
- `NUM_NIB`, default 4: nibbles per word; legal values ≥ 2.
- `CNT_W`, default `$clog2(NUM_NIB+1)`: width of the count outputs. Derived; do not override.
- `clk` in, 1 bit: single clock, rising edge.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `in_valid` in, 1 bit: nibble offered.
- `in_ready` out, 1 bit: nibble accepted when `in_valid && in_ready`.
- `in_nib` in, 4 bits: nibble data.
- `in_flag` in, 1 bit: nibble all-ones flag from upstream. Counted only; not checked against `in_nib`.
- `in_last` in, 1 bit: closes the current word after this nibble.
- `out_valid` out, 1 bit: packed word available.
- `out_ready` in, 1 bit: word consumed when `out_valid && out_ready`.
- `out_data` out, `4*NUM_NIB` bits: slot k occupies bits `[4k+3:4k]`; slot 0 is the first nibble.
- `out_cnt` out, `CNT_W` bits: number of valid slots, 1..`NUM_NIB`.
- `out_flags` out, `CNT_W` bits: number of accepted nibbles with `in_flag=1`.
- `out_parity` out, 1 bit: present only with `NIBBLE_PACKER_PARITY_EN`.

## Operation
**Accumulator FSM**
- `ACC_FILL`: `in_ready=1`.
  - Each accepted nibble is written to slot `idx`; `idx` increments.
  - `flag_cnt` increments when `in_flag=1`.
  - The word completes when the accepted nibble has `idx==NUM_NIB-1` or `in_last=1`. Both conditions in the same beat produce one word with `cnt=NUM_NIB`.
- On completion:
  - If the output register is empty, or is draining this cycle (`out_valid && out_ready`), the word, count and flags load into it. The accumulator clears (data 0, `idx` 0, `flag_cnt` 0) and stays in `ACC_FILL`.
  - Otherwise go to `ACC_HELD`.
- `ACC_HELD`: `in_ready=0`; the completed word is frozen. On an output handshake the word transfers to the output register in that same clock edge; the accumulator clears and returns to `ACC_FILL`.

**Output register**
- `out_valid` sets on load and clears on handshake unless reloaded in the same edge.
- `out_data`, `out_cnt`, `out_flags` and `out_parity` are stable while `out_valid && !out_ready`.

**Other rules**
- Unfilled slots of an early-closed word read 0.
- `in_ready` is a function of state only. It never depends on `in_valid`, `in_last` or `out_ready`.
- Reset (asynchronous, any time, including mid-word):
  - `out_valid=0`, `out_data=0`, `out_cnt=0`, `out_flags=0`, `out_parity=0`.
  - `in_ready=1`; the accumulator clears and the FSM enters `ACC_FILL`.
  - Partial words are discarded.

## Timing
- Latency: the word appears on `out_*` in the cycle after the completing nibble is accepted, provided the output register is free or draining.
- Throughput: 1 nibble/cycle sustained with `out_ready=1`; one word per `NUM_NIB` cycles, or per closure.
- Backpressure:
  - With `out_ready=0`, one word waits in the output register and a second completes in the accumulator.
  - `in_ready` drops in the cycle after the second word completes.
  - `in_ready` returns to 1 in the cycle after the first output handshake.
- A cycle with an output handshake and an accumulator completion at the same time loads the new word into the output register with no bubble.

## Configuration
- `NIBBLE_PACKER_PARITY_EN` defined:
  - `out_parity` port exists and equals the XOR of all bits of the registered `out_data`.
  - Parity is computed in the accumulator and registered with the word, so there is no extra latency.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `nibble_pkg`:
  - `NIB_W = 4`.
  - Accumulator state enum `acc_state_e` {`ACC_FILL`, `ACC_HELD`}.
  - Function `nib_cnt_w(n)` returning `$clog2(n+1)`.
- One sub-module, `nibble_acc`: slot write, `idx`, flag counter and completion detect. The top level holds the FSM, the output register and the handshakes.

## Test plan
All scenarios use `NUM_NIB=4`.
1. Nibbles 1,2,3,4 with `out_ready=1` → `out_data=16'h4321`, `out_cnt=4`, `out_valid` high for 1 cycle, in the cycle after the 4th accept.
2. Nibbles 5, 6, with `in_last` on 6 → `out_data=16'h0065`, `out_cnt=2`; the next nibble lands in slot 0.
3. `out_ready=0`, then 8 nibbles 1..8 → `in_ready=0` after the 8th. Raise `out_ready` → `16'h4321` then `16'h8765` on consecutive handshakes; `in_ready=1` again in the cycle after the first handshake.
4. Nibbles F,0,F,F with flags 1,0,1,1 → `out_data=16'hFF0F`, `out_flags=3`.
5. Two nibbles accepted, then `rst_n` pulsed low mid-cycle → outputs 0 immediately. Nibbles A,B,C,D after release → `out_data=16'hDCBA`.
6. With `NIBBLE_PACKER_PARITY_EN`, scenario 1 → `out_parity=1`. Nibbles 3,3,0,0 → `out_parity=0`.
